// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder: response entries carried through the
// delay line, the grant FSM state encoding and a byte-lane merge helper.
package data_mem_pkg;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } rsp_entry_t;

   localparam rsp_entry_t RSP_EMPTY = '{valid: 1'b0, err: 1'b0, rdata: 32'h0};

   localparam logic [6:0] RDATA_INTG_ZERO = 7'b0;

   typedef enum logic [0:0] {
      StIdle,
      StWait
   } gnt_state_e;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
      logic [31:0] result;
      for (int k = 0; k < 4; k++) begin
         result[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency, never-stalling in-order delay line for memory responses; an entry pushed at one
// edge appears on rsp_o RSP_LAT cycles later.
module mem_rsp_pipe
   import data_mem_pkg::*;
#(
   parameter int unsigned RSP_LAT = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  rsp_entry_t rsp_i,
   output rsp_entry_t rsp_o
);

   rsp_entry_t stage_q [RSP_LAT];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < RSP_LAT; i++) begin
            stage_q[i] <= RSP_EMPTY;
         end
      end else begin
         stage_q[0] <= rsp_i;
         for (int unsigned i = 1; i < RSP_LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign rsp_o = stage_q[RSP_LAT-1];

endmodule

// File: rtl/data_mem_responder.sv
// Behavioural word-addressed data memory with a configurable grant delay and a fixed-latency
// response path; out-of-range accesses answer with an error and leave the array untouched.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned GNT_WAIT    = 0,
   parameter int unsigned RSP_LAT     = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic [6:0]  data_wdata_intg_i,
   output logic [31:0] data_rdata_o,
   output logic [6:0]  data_rdata_intg_o,
   output logic        data_err_o
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_INIT = 4'(GNT_WAIT);

   gnt_state_e  state_q;
   logic [3:0]  cnt_q;
   logic        gnt;
   logic [31:0] offset;
   logic        in_range;
   logic [AW-1:0] word_idx;
   logic [31:0] mem_q [DEPTH_WORDS];
   rsp_entry_t  rsp_in;
   rsp_entry_t  rsp_out;
   logic        unused_intg;

   // The grant lands in the cycle whose closing edge takes the counter to zero, so req is held
   // for exactly GNT_WAIT cycles before the granting cycle. Reset masks the grant, which also
   // blocks any write commit while RST_N is low.
   always_comb begin
      gnt = 1'b0;
      if (RST_N && data_req_i) begin
         case (state_q)
            StIdle:  gnt = (GNT_WAIT == 0);
            StWait:  gnt = (cnt_q == 4'd1);
            default: gnt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (data_req_i && (GNT_WAIT != 0)) begin
                  state_q <= StWait;
                  cnt_q   <= WAIT_INIT;
               end
            end
            StWait: begin
               if (!data_req_i || (cnt_q == 4'd1)) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // 33-bit compare keeps the window correct when it ends exactly at the top of the address space.
   assign offset   = data_addr_i - BASE_ADDR;
   assign in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);
   assign word_idx = offset[AW+1:2];

   always_ff @(posedge CLK) begin
      if (gnt && data_we_i && in_range) begin
         mem_q[word_idx] <= merge_bytes(mem_q[word_idx], data_wdata_i, data_be_i);
      end
   end

   always_comb begin
      rsp_in = RSP_EMPTY;
      if (gnt) begin
         rsp_in.valid = 1'b1;
         rsp_in.err   = !in_range;
         if (in_range && !data_we_i) begin
            rsp_in.rdata = mem_q[word_idx];
         end
      end
   end

   mem_rsp_pipe #(
      .RSP_LAT (RSP_LAT)
   ) u_rsp_pipe (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .rsp_i  (rsp_in),
      .rsp_o  (rsp_out)
   );

   assign data_gnt_o        = gnt;
   assign data_rvalid_o     = rsp_out.valid;
   assign data_rdata_o      = rsp_out.valid ? rsp_out.rdata : 32'h0;
   assign data_err_o        = rsp_out.valid & rsp_out.err;
   assign data_rdata_intg_o = RDATA_INTG_ZERO;

   assign unused_intg = ^data_wdata_intg_i;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responder instances (zero-wait/1-cycle, 3-wait grant, 3-cycle latency)
// driven from a vector table plus hand-written multi-cycle sequences.
module tb_data_mem_responder;

   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req   [N];
   logic        we    [N];
   logic [3:0]  be    [N];
   logic [31:0] addr  [N];
   logic [31:0] wdata [N];
   logic        gnt   [N];
   logic        rvalid[N];
   logic [31:0] rdata [N];
   logic [6:0]  rintg [N];
   logic        err   [N];
   logic [6:0]  wintg;

   int checks   = 0;
   int failures = 0;

   data_mem_responder #(
      .DEPTH_WORDS (16), .BASE_ADDR (32'h0000_0000), .GNT_WAIT (0), .RSP_LAT (1)
   ) u_dut0 (
      .CLK (clk), .RST_N (rst_n), .data_req_i (req[0]), .data_gnt_o (gnt[0]),
      .data_rvalid_o (rvalid[0]), .data_we_i (we[0]), .data_be_i (be[0]),
      .data_addr_i (addr[0]), .data_wdata_i (wdata[0]), .data_wdata_intg_i (wintg),
      .data_rdata_o (rdata[0]), .data_rdata_intg_o (rintg[0]), .data_err_o (err[0])
   );

   data_mem_responder #(
      .DEPTH_WORDS (16), .BASE_ADDR (32'h0000_0000), .GNT_WAIT (3), .RSP_LAT (1)
   ) u_dut1 (
      .CLK (clk), .RST_N (rst_n), .data_req_i (req[1]), .data_gnt_o (gnt[1]),
      .data_rvalid_o (rvalid[1]), .data_we_i (we[1]), .data_be_i (be[1]),
      .data_addr_i (addr[1]), .data_wdata_i (wdata[1]), .data_wdata_intg_i (wintg),
      .data_rdata_o (rdata[1]), .data_rdata_intg_o (rintg[1]), .data_err_o (err[1])
   );

   data_mem_responder #(
      .DEPTH_WORDS (16), .BASE_ADDR (32'h0000_1000), .GNT_WAIT (0), .RSP_LAT (3)
   ) u_dut2 (
      .CLK (clk), .RST_N (rst_n), .data_req_i (req[2]), .data_gnt_o (gnt[2]),
      .data_rvalid_o (rvalid[2]), .data_we_i (we[2]), .data_be_i (be[2]),
      .data_addr_i (addr[2]), .data_wdata_i (wdata[2]), .data_wdata_intg_i (wintg),
      .data_rdata_o (rdata[2]), .data_rdata_intg_o (rintg[2]), .data_err_o (err[2])
   );

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int k, input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
      req[k]   = r;
      we[k]    = w;
      be[k]    = b;
      addr[k]  = a;
      wdata[k] = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      wintg = 7'h55;
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      vecs[0]  = '{1'b1, 4'hF,    32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 4'hF,    32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 4'hF,    32'h20, 32'hFFFFFFFF, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 4'b0101, 32'h20, 32'h11223344, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 4'hF,    32'h20, 32'h0,        1'b0, 32'hFF22FF44};
      vecs[5]  = '{1'b1, 4'hF,    32'h00, 32'hA5A5A5A5, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 4'hF,    32'h40, 32'h0,        1'b1, 32'h0};
      vecs[7]  = '{1'b1, 4'hF,    32'h40, 32'h12345678, 1'b1, 32'h0};
      vecs[8]  = '{1'b0, 4'hF,    32'h00, 32'h0,        1'b0, 32'hA5A5A5A5};
      vecs[9]  = '{1'b1, 4'hF,    32'h3C, 32'h0BADF00D, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 4'hF,    32'h3F, 32'h0,        1'b0, 32'h0BADF00D};
      vecs[11] = '{1'b1, 4'b0010, 32'h11, 32'h0000AB00, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 4'hF,    32'h12, 32'h0,        1'b0, 32'hDEADABEF};

      // Reset and the state in the cycle after the reset edge.
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         check($sformatf("rst%0d_gnt", k), gnt[k], 0);
         check($sformatf("rst%0d_rvalid", k), rvalid[k], 0);
         check($sformatf("rst%0d_rdata", k), rdata[k], 0);
         check($sformatf("rst%0d_err", k), err[k], 0);
         check($sformatf("rst%0d_rintg", k), rintg[k], 0);
      end
      next_cycle();

      // Table vectors on the zero-wait, 1-cycle-latency instance.
      for (int i = 0; i < NV; i++) begin
         drive(0, 1'b1, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
         @(negedge clk);
         check($sformatf("v%0d_gnt", i), gnt[0], 1);
         check($sformatf("v%0d_rvalid_early", i), rvalid[0], 0);
         next_cycle();
         drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         @(negedge clk);
         check($sformatf("v%0d_rvalid", i), rvalid[0], 1);
         check($sformatf("v%0d_err", i), err[0], 32'(vecs[i].exp_err));
         check($sformatf("v%0d_rdata", i), rdata[0], vecs[i].exp_rdata);
         check($sformatf("v%0d_rintg", i), rintg[0], 0);
         next_cycle();
      end

      // GNT_WAIT=3: grant in the 4th cycle of a held request.
      drive(1, 1'b1, 1'b1, 4'hF, 32'h4, 32'h55AA55AA);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("wait_w_c%0d_gnt", c), gnt[1], 32'(c == 4));
         next_cycle();
      end
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("wait_w_rvalid", rvalid[1], 1);
      check("wait_w_rdata", rdata[1], 0);
      next_cycle();

      // Request abandoned after 2 cycles: no grant, no response.
      drive(1, 1'b1, 1'b1, 4'hF, 32'h4, 32'h0);
      for (int c = 0; c < 8; c++) begin
         if (c == 2) drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         @(negedge clk);
         check($sformatf("drop_c%0d_gnt", c), gnt[1], 0);
         check($sformatf("drop_c%0d_rvalid", c), rvalid[1], 0);
         next_cycle();
      end

      // Read back: shows the abandoned write was not committed.
      drive(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("wait_r_c%0d_gnt", c), gnt[1], 32'(c == 4));
         next_cycle();
      end
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("wait_r_rvalid", rvalid[1], 1);
      check("wait_r_rdata", rdata[1], 32'h55AA55AA);
      next_cycle();

      // RSP_LAT=3: back-to-back writes then back-to-back reads.
      for (int t = 0; t < 5; t++) begin
         drive(2, 1'b1, 1'b1, 4'hF, 32'h1000 + 32'(4 * t), 32'hC0DE0000 | 32'(t));
         @(negedge clk);
         check($sformatf("lat_w%0d_gnt", t), gnt[2], 1);
         next_cycle();
      end
      drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (4) next_cycle();
      for (int t = 0; t < 9; t++) begin
         if (t < 5) drive(2, 1'b1, 1'b0, 4'hF, 32'h1000 + 32'(4 * t), 32'h0);
         else       drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         @(negedge clk);
         check($sformatf("lat_r%0d_gnt", t), gnt[2], 32'(t < 5));
         check($sformatf("lat_r%0d_rvalid", t), rvalid[2], 32'(t >= 3 && t < 8));
         check($sformatf("lat_r%0d_rdata", t), rdata[2],
               (t >= 3 && t < 8) ? (32'hC0DE0000 | 32'(t - 3)) : 32'h0);
         next_cycle();
      end

      // Reset with two reads in flight; a write presented during reset must not commit.
      for (int t = 0; t < 2; t++) begin
         drive(2, 1'b1, 1'b0, 4'hF, 32'h1000 + 32'(4 * t), 32'h0);
         @(negedge clk);
         check($sformatf("inflight%0d_gnt", t), gnt[2], 1);
         next_cycle();
      end
      drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h0);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_gnt0", gnt[0], 0);
      check("rst_mid_rvalid2", rvalid[2], 0);
      next_cycle();
      rst_n = 1'b1;
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("post_rst_c%0d_rvalid2", c), rvalid[2], 0);
         check($sformatf("post_rst_c%0d_rdata2", c), rdata[2], 0);
         check($sformatf("post_rst_c%0d_rvalid0", c), rvalid[0], 0);
         next_cycle();
      end

      // Normal completion after reset.
      for (int c = 0; c < 4; c++) begin
         if (c == 0) drive(2, 1'b1, 1'b0, 4'hF, 32'h1008, 32'h0);
         else        drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         @(negedge clk);
         check($sformatf("after_rst_c%0d_gnt", c), gnt[2], 32'(c == 0));
         check($sformatf("after_rst_c%0d_rvalid", c), rvalid[2], 32'(c == 3));
         check($sformatf("after_rst_c%0d_rdata", c), rdata[2],
               (c == 3) ? 32'hC0DE0002 : 32'h0);
         next_cycle();
      end

      // Word 4 of instance 0 still holds its pre-reset value.
      drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      @(negedge clk);
      check("keep_gnt", gnt[0], 1);
      next_cycle();
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("keep_rvalid", rvalid[0], 1);
      check("keep_rdata", rdata[0], 32'hDEADABEF);
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
